// File: rtl/eth_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_frame_rx                                                 |
// | Description : 10BASE-T bit-serial frame receiver. Hunts the alternating   |
// |               preamble and "11" SFD on the decoded LSB-first bit stream,  |
// |               assembles bytes and streams them out with SOF/EOF framing,  |
// |               reporting frame length and alignment/length/FCS errors.     |
// |               Optional FCS checking is built when ETH_RX_CRC_CHECK_EN is  |
// |               defined; otherwise rx_err_crc is tied low.                  |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module eth_frame_rx #(
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11,
  parameter int MIN_PRE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             rx_bit,
  input  logic             rx_carrier,
  output logic [7:0]       rx_byte,
  output logic             rx_byte_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic [LEN_W-1:0] rx_len,
  output logic             rx_err_align,
  output logic             rx_err_long,
  output logic             rx_err_crc,
  output logic             rx_busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2
  } state_t;

  localparam logic [5:0]       c_PRE_SAT = 6'd63;
  localparam logic [5:0]       c_MIN_PRE = 6'(MIN_PRE);
  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_pre_cnt;
  logic       r_prev;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;

  // Per-strobe decoded events
  logic w_start_pre;
  logic w_pre_alt;
  logic w_pre_clr;
  logic w_sfd;
  logic w_data_bit;
  logic w_eof;
  logic w_byte_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and per-strobe event generation
  always_comb begin
    w_state_nxt = r_state;
    w_start_pre = 1'b0;
    w_pre_alt   = 1'b0;
    w_pre_clr   = 1'b0;
    w_sfd       = 1'b0;
    w_data_bit  = 1'b0;
    w_eof       = 1'b0;
    if (enable) begin
      case (r_state)
        S_IDLE: begin
          if (rx_carrier && rx_bit) begin
            w_state_nxt = S_PREAMBLE;
            w_start_pre = 1'b1;
          end
        end
        S_PREAMBLE: begin
          if (!rx_carrier) begin
            w_state_nxt = S_IDLE;
          end else if (rx_bit != r_prev) begin
            w_pre_alt = 1'b1;
          end else if (rx_bit && (r_pre_cnt >= c_MIN_PRE)) begin
            w_sfd       = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_pre_clr = 1'b1;
          end
        end
        S_DATA: begin
          if (rx_carrier) begin
            w_data_bit = 1'b1;
          end else begin
            w_eof       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_byte_done = w_data_bit && (r_bit_cnt == 3'd7);
  assign rx_busy     = (r_state != S_IDLE);

  // Preamble run-length counter; a repeated bit restarts the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= 6'd0;
      r_prev    <= 1'b0;
    end else if (w_start_pre) begin
      r_pre_cnt <= 6'd1;
      r_prev    <= 1'b1;
    end else if (w_pre_alt) begin
      if (r_pre_cnt != c_PRE_SAT) r_pre_cnt <= r_pre_cnt + 6'd1;
      r_prev <= rx_bit;
    end else if (w_pre_clr) begin
      r_pre_cnt <= 6'd0;
      r_prev    <= rx_bit;
    end
  end

  // Byte under assembly with the current bit merged in at its LSB-first slot
  always_comb begin
    w_shift_nxt            = r_shift;
    w_shift_nxt[r_bit_cnt] = rx_bit;
  end

  // Byte assembly register and bit position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= 8'd0;
      r_bit_cnt <= 3'd0;
    end else if (w_sfd) begin
      r_bit_cnt <= 3'd0;
    end else if (w_data_bit) begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Byte/EOF pulses, length and alignment/length error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte       <= 8'd0;
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_len        <= '0;
      rx_err_align  <= 1'b0;
      rx_err_long   <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      if (w_sfd) begin
        rx_len       <= '0;
        rx_err_align <= 1'b0;
        rx_err_long  <= 1'b0;
      end
      if (w_byte_done) begin
        if (rx_len < c_MAX_LEN) begin
          rx_byte       <= w_shift_nxt;
          rx_byte_valid <= 1'b1;
          rx_sof        <= (rx_len == '0);
          rx_len        <= rx_len + LEN_W'(1);
        end else begin
          // Oversized frame: byte is dropped, length stays pinned at the limit
          rx_err_long <= 1'b1;
        end
      end
      if (w_eof) begin
        rx_eof       <= 1'b1;
        rx_err_align <= (r_bit_cnt != 3'd0);
      end
    end
  end

`ifdef ETH_RX_CRC_CHECK_EN
  localparam logic [31:0] c_CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] c_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] c_CRC_RESIDUE = 32'hDEBB_20E3;

  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;

  // One reflected CRC-32 step for the current line bit
  always_comb begin
    w_crc_nxt = {1'b0, r_crc[31:1]} ^ ((r_crc[0] ^ rx_bit) ? c_CRC_POLY : 32'd0);
  end

  // Running CRC over all data bits, FCS included; residue compared at EOF
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc      <= c_CRC_INIT;
      rx_err_crc <= 1'b0;
    end else begin
      if (w_sfd)           r_crc <= c_CRC_INIT;
      else if (w_data_bit) r_crc <= w_crc_nxt;
      if (w_sfd) begin
        rx_err_crc <= 1'b0;
      end else if (w_eof) begin
        rx_err_crc <= (r_crc != c_CRC_RESIDUE) | (r_bit_cnt != 3'd0) | rx_err_long;
      end
    end
  end
`else
  assign rx_err_crc = 1'b0;
`endif

endmodule
`default_nettype wire
